// File: rtl/otter_mem_pkg.sv
// Shared types and size encodings for the OTTER memory controller.
package otter_mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        MEM_BYTE = SIZE_BYTE,
        MEM_HALF = SIZE_HALF,
        MEM_WORD = SIZE_WORD
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
module mem_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misaligned halves/words fall onto the aligned lanes because only the
    // relevant offset bits participate in the lane selection.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_size)
            SIZE_BYTE: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            SIZE_WORD: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = st_data;
            end
        endcase
    end

    assign ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
    assign ld_half = ld_word[{ld_offset[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SIZE_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store memory controller for the OTTER CPU in front of a byte-enabled block RAM.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them down.
module mem_ctrl
    import otter_mem_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      ram_rd,
    output logic [3:0]                ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata
);

    state_t      state;
    logic [1:0]  ld_size;
    logic [1:0]  ld_offset;
    logic        ld_unsigned;
    logic        accept;
    logic        misalign;
    logic        req_err;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign req_ready = (state == ST_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                      ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (|req_addr[31:RAM_ADDR_WIDTH+2]) || (req_size == SIZE_ILLEGAL) || misalign;

    mem_align u_align (
        .st_size     (req_size),
        .st_offset   (req_addr[1:0]),
        .st_data     (req_wdata),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_size     (ld_size),
        .ld_offset   (ld_offset),
        .ld_unsigned (ld_unsigned),
        .ld_word     (ram_rdata),
        .ld_data     (ld_data)
    );

    // RAM strobes exist only in the accept cycle so rejected requests never touch memory.
    assign ram_rd    = !(accept && !req_we && !req_err);
    assign ram_we    = (accept && req_we && !req_err) ? st_be : 4'b0000;
    assign ram_addr  = accept ? req_addr[RAM_ADDR_WIDTH+1:2] : '0;
    assign ram_wdata = accept ? st_wdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            ld_size     <= SIZE_WORD;
            ld_offset   <= 2'b00;
            ld_unsigned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    if (req_valid) begin
                        if (req_err || req_we) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                            state     <= ST_RESP;
                        end else begin
                            ld_size     <= req_size;
                            ld_offset   <= req_addr[1:0];
                            ld_unsigned <= req_unsigned;
                            state       <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                    rsp_err   <= 1'b0;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural byte-enabled RAM and a response scoreboard.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_rd;
    logic [3:0]  ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:8191];

    mem_ctrl #(.RAM_ADDR_WIDTH(13)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_rd       (ram_rd),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Block RAM with byte write enables and registered read data
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        if (!ram_rd) ram_rdata <= mem[ram_addr];
    end

    // Response monitor: every rsp_valid must match the oldest scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp got rsp_valid=1 exp no response (rdata=%h err=%b)", rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                checks++;
                if (rsp_rdata !== e.rdata) begin
                    failures++;
                    $display("[TB] FAIL rsp_rdata got=%h exp=%h", rsp_rdata, e.rdata);
                end
                checks++;
                if (rsp_err !== e.err) begin
                    failures++;
                    $display("[TB] FAIL rsp_err got=%b exp=%b", rsp_err, e.err);
                end
                checks++;
                if (ncyc !== e.due) begin
                    failures++;
                    $display("[TB] FAIL rsp_latency got cycle=%0d exp cycle=%0d", ncyc, e.due);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int waited = 0;
        while (sb.size() != 0 && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.timeout got pending=%0d exp pending=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic drive_request(input string name, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t e;
        logic exp_rd;
        exp_rd = !(!we && !exp_err);
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s.req_ready got=%b exp=1", name, req_ready);
        end
        checks++;
        if (ram_rd !== exp_rd) begin
            failures++;
            $display("[TB] FAIL %s.ram_rd got=%b exp=%b", name, ram_rd, exp_rd);
        end
        checks++;
        if (ram_we !== exp_be) begin
            failures++;
            $display("[TB] FAIL %s.ram_we got=%b exp=%b", name, ram_we, exp_be);
        end
        if (!exp_err) begin
            checks++;
            if (ram_addr !== addr[14:2]) begin
                failures++;
                $display("[TB] FAIL %s.ram_addr got=%h exp=%h", name, ram_addr, addr[14:2]);
            end
        end
        if (we && !exp_err) begin
            checks++;
            if (ram_wdata !== exp_wdata) begin
                failures++;
                $display("[TB] FAIL %s.ram_wdata got=%h exp=%h", name, ram_wdata, exp_wdata);
            end
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.due   = ncyc + ((!we && !exp_err) ? 2 : 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hXXXX_XXXX;
        req_wdata = 32'hXXXX_XXXX;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s.busy_ready got=%b exp=0", name, req_ready);
        end
        #1;
        wait_drain(name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset.rsp got valid=%b rdata=%h err=%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (ram_rd !== 1'b1 || ram_we !== 4'b0000 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset.ram got rd=%b we=%b ready=%b exp 1/0000/1", ram_rd, ram_we, req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        drive_request("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
        drive_request("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_byte;
        drive_request("st_byte", 1'b1, 2'b00, 1'b0, 32'h103, 32'hAAAA_AA80, 32'h0, 1'b0, 4'b1000, 32'h80808080);
        drive_request("ld_sbyte", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 32'h0);
        drive_request("ld_ubyte", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_half;
        drive_request("st_half", 1'b1, 2'b01, 1'b0, 32'h102, 32'h5555_1234, 32'h0, 1'b0, 4'b1100, 32'h12341234);
        drive_request("ld_uhalf", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h00001234, 1'b0, 4'b0000, 32'h0);
        drive_request("ld_word_hi", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1234BEEF, 1'b0, 4'b0000, 32'h0);
        drive_request("ld_sbyte1", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0);
        drive_request("ld_shalf0", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_errors;
        drive_request("err_range", 1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        drive_request("err_size", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        drive_request("err_st_range", 1'b1, 2'b10, 1'b0, 32'h8000_0100, 32'h0BAD_0BAD, 32'h0, 1'b1, 4'b0000, 32'h0);
        drive_request("ld_after_err", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1234BEEF, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
        drive_request("mis_word", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        drive_request("mis_half", 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
`else
        drive_request("mis_word", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h1234BEEF, 1'b0, 4'b0000, 32'h0);
        drive_request("mis_half", 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h00001234, 1'b0, 4'b0000, 32'h0);
`endif
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h200;
        req_wdata = 32'h11111111;
        @(negedge clk);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.due   = ncyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_addr  = 32'h204;
        req_wdata = 32'h22222222;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b.ready_n1 got=%b exp=0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ram_we !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL b2b.second_accept got ready=%b we=%b exp 1/1111", req_ready, ram_we);
        end
        e.due = ncyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_drain("b2b");
        drive_request("b2b_ld0", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h11111111, 1'b0, 4'b0000, 32'h0);
        drive_request("b2b_ld1", 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h22222222, 1'b0, 4'b0000, 32'h0);
    endtask

    task automatic test_random_words;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            a = {17'b0, 13'($urandom_range(256, 8191)), 2'b00};
            d = $urandom;
            drive_request("rnd_st", 1'b1, 2'b10, 1'b0, a, d, 32'h0, 1'b0, 4'b1111, d);
            drive_request("rnd_ld", 1'b0, 2'b10, 1'b0, a, 32'h0, d, 1'b0, 4'b0000, 32'h0);
        end
    endtask

    task automatic test_reset_mid_op;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid.in_reset got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid.after got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
        end
        drive_request("rst_mid_ld", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1234BEEF, 1'b0, 4'b0000, 32'h0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_random_words();
        test_reset_mid_op();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got running exp finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
